// File: rtl/vend_coin_driver.sv
// Coin sequencer for the shape-coin acceptor: buys N sodas with one-hot presses,
// checks every acceptor response. Define VEND_PENTAGON_EN to allow pentagon coins.
module vend_coin_driver #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_sodas,
  input  logic [1:0]       credit_in,
  input  logic             drop_in,
  output logic             circle,
  output logic             triangle,
  output logic             pentagon,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] sodas_got,
  output logic [7:0]       coins_used
);

  localparam int unsigned TMAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W = $clog2(TMAX + 1);
`ifdef VEND_PENTAGON_EN
  localparam int unsigned NSHAPE = 3;
`else
  localparam int unsigned NSHAPE = 2;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_HOLD, S_GAP, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [CNT_W-1:0]  sodas_q, sodas_d;
  logic [7:0]        coins_q, coins_d;
  logic [7:0]        soda_coins_q, soda_coins_d;
  logic [NSHAPE-1:0] shape_q, shape_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [1:0]        exp_credit_q, exp_credit_d;
  logic              exp_drop_q, exp_drop_d;
  logic              drop_seen_q, drop_seen_d;
  logic              drop_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              drop_rise;
  logic [NSHAPE-1:0] pick_shape;
  logic [3:0]        coin_val;
  logic [3:0]        credit_sum;
  logic [7:0]        soda_base;

  // Coin choice from the credit currently shown by the acceptor
  always_comb begin
    pick_shape = NSHAPE'(1);
    coin_val   = 4'd1;
    if (credit_in <= 2'd1) begin
      pick_shape = NSHAPE'(2);
      coin_val   = 4'd3;
    end
`ifdef VEND_PENTAGON_EN
    if (credit_in == 2'd0) begin
      pick_shape = NSHAPE'(4);
      coin_val   = 4'd5;
    end
`endif
    credit_sum = {2'b00, credit_in} + coin_val;
  end

  assign drop_rise = drop_in & ~drop_q & (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    sodas_d      = sodas_q;
    coins_d      = coins_q;
    soda_coins_d = soda_coins_q;
    shape_d      = shape_q;
    timer_d      = timer_q;
    exp_credit_d = exp_credit_q;
    exp_drop_d   = exp_drop_q;
    drop_seen_d  = drop_seen_q;
    done_d       = 1'b0;
    soda_base    = soda_coins_q;

    // Drop edges are applied first so CHECK compares against the updated view
    if (drop_rise) begin
      sodas_d      = sodas_q + CNT_W'(1);
      drop_seen_d  = 1'b1;
      soda_coins_d = '0;
      soda_base    = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_sodas != '0) begin
            target_d     = num_sodas;
            sodas_d      = '0;
            coins_d      = '0;
            soda_coins_d = '0;
            drop_seen_d  = 1'b0;
            state_d      = S_PICK;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_PICK: begin
        exp_credit_d = credit_sum[1:0];
        exp_drop_d   = (credit_sum[3:2] != 2'b00);
        drop_seen_d  = 1'b0;
        shape_d      = pick_shape;
        coins_d      = (coins_q == 8'hFF) ? coins_q : coins_q + 8'd1;
        soda_coins_d = (soda_base == 8'hFF) ? soda_base : soda_base + 8'd1;
        timer_d      = '0;
        state_d      = S_HOLD;
      end
      S_HOLD: begin
        if (timer_q == TMR_W'(HOLD_CYCLES - 1)) begin
          timer_d = '0;
          shape_d = '0;
          state_d = S_GAP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_GAP: begin
        if (timer_q == TMR_W'(GAP_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_CHECK;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_CHECK: begin
        if ((credit_in != exp_credit_q) || (drop_seen_d != exp_drop_q) ||
            (soda_coins_d > 8'(TIMEOUT))) begin
          state_d = S_ERROR;
        end else if (sodas_d == target_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_PICK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: begin
        shape_d = '0;
        state_d = S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    error_d = (state_d == S_ERROR);
    if (state_d == S_DONE) done_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      target_q     <= '0;
      sodas_q      <= '0;
      coins_q      <= '0;
      soda_coins_q <= '0;
      shape_q      <= '0;
      timer_q      <= '0;
      exp_credit_q <= '0;
      exp_drop_q   <= 1'b0;
      drop_seen_q  <= 1'b0;
      drop_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      sodas_q      <= sodas_d;
      coins_q      <= coins_d;
      soda_coins_q <= soda_coins_d;
      shape_q      <= shape_d;
      timer_q      <= timer_d;
      exp_credit_q <= exp_credit_d;
      exp_drop_q   <= exp_drop_d;
      drop_seen_q  <= drop_seen_d;
      drop_q       <= drop_in;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign circle     = shape_q[0];
  assign triangle   = shape_q[1];
`ifdef VEND_PENTAGON_EN
  assign pentagon   = shape_q[2];
`else
  assign pentagon   = 1'b0;
`endif
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign sodas_got  = sodas_q;
  assign coins_used = coins_q;

endmodule

// File: tb/tb_vend_coin_driver.sv
// Bench for vend_coin_driver: plays the acceptor, predicts coin sequences and
// totals from the pricing rules, and scoreboards them against the DUT.
`timescale 1ns/1ps
module tb_vend_coin_driver;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_sodas = '0;
  logic [1:0]       credit_in = '0;
  logic             drop_in = 1'b0;
  logic             circle, triangle, pentagon, busy, done, error;
  logic [CNT_W-1:0] sodas_got;
  logic [7:0]       coins_used;

  vend_coin_driver #(.HOLD_CYCLES(2), .GAP_CYCLES(2), .CNT_W(CNT_W), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .start(start), .num_sodas(num_sodas),
    .credit_in(credit_in), .drop_in(drop_in), .circle(circle), .triangle(triangle),
    .pentagon(pentagon), .busy(busy), .done(done), .error(error),
    .sodas_got(sodas_got), .coins_used(coins_used)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct { int sodas; int coins; int busy; } done_exp_t;
  logic [2:0] exp_coin[$];
  done_exp_t  exp_done[$];
  int         exp_err = 0;
  int         last_sodas = 0;
  int         last_coins = 0;

  // Acceptor model: credit mod 4, drop pulse of random width on each overflow
  int         acc_credit = 0;
  bit         acc_stuck = 1'b0;
  int         drop_left = 0;
  logic [2:0] acc_prev = '0;
  always @(negedge clock) begin
    logic [2:0] shp;
    int v;
    shp = {pentagon, triangle, circle};
    if (drop_left > 0) drop_left--;
    if (drop_left == 0) drop_in = 1'b0;
    if (shp != 3'b000 && acc_prev == 3'b000 && !acc_stuck) begin
      v = shp[2] ? 5 : (shp[1] ? 3 : 1);
      acc_credit += v;
      if (acc_credit >= 4) begin
        acc_credit -= 4;
        drop_in = 1'b1;
        drop_left = $urandom_range(1, 3);
      end
    end
    credit_in = acc_stuck ? 2'd0 : 2'(acc_credit);
    acc_prev = shp;
  end

  // Monitor
  logic [2:0] mon_prev = '0;
  int         hold_len = 0;
  int         gap_len = 100;
  bit         abort_flag = 1'b0;
  logic       err_prev = 1'b0;
  always @(negedge clock) begin
    logic [2:0] shp;
    logic [2:0] e;
    done_exp_t  d;
    shp = {pentagon, triangle, circle};
    chk("shape_onehot", int'($countones(shp) <= 1), 1);
    if (shp != 3'b000 && mon_prev == 3'b000) begin
      chk("gap_before_coin", int'(gap_len >= 2), 1);
      if (exp_coin.size() == 0) chk("unexpected_coin", shp, 0);
      else begin
        e = exp_coin.pop_front();
        chk("coin_shape", shp, e);
      end
      hold_len = 1;
    end else if (shp != 3'b000) begin
      hold_len++;
    end else if (mon_prev != 3'b000) begin
      if (abort_flag) abort_flag = 1'b0;
      else chk("hold_len", hold_len, 2);
      gap_len = 1;
    end else begin
      gap_len++;
    end
    if (error) chk("shape_in_error", shp, 0);
    if (error && !err_prev) begin
      chk("error_expected", int'(exp_err > 0), 1);
      if (exp_err > 0) exp_err--;
    end
    if (done) begin
      if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        d = exp_done.pop_front();
        chk("done_sodas", sodas_got, d.sodas);
        chk("done_coins", coins_used, d.coins);
        chk("done_busy", busy, d.busy);
        chk("done_error", error, 0);
      end
    end
    err_prev = error;
    mon_prev = shp;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reference: greedy coin choice by deficit to the next soda
  task automatic model_request(input int n);
    int c, drops, coins, v;
    logic [2:0] s;
    done_exp_t d;
    if (n == 0) begin
      d = '{last_sodas, last_coins, 0};
      exp_done.push_back(d);
      return;
    end
    c = acc_credit; drops = 0; coins = 0;
    while (drops < n) begin
      if ((4 - c) >= 3) begin v = 3; s = 3'b010; end
      else begin v = 1; s = 3'b001; end
`ifdef VEND_PENTAGON_EN
      if ((4 - c) == 4) begin v = 5; s = 3'b100; end
`endif
      exp_coin.push_back(s);
      coins++;
      c += v;
      if (c >= 4) begin c -= 4; drops++; end
    end
    d = '{n, coins, 1};
    exp_done.push_back(d);
    last_sodas = n;
    last_coins = coins;
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while ((busy || done) && k < limit) begin
      @(negedge clock);
      k++;
    end
    if (busy || done) chk("idle_timeout", 1, 0);
  endtask

  task automatic request(input int n, input bit poke);
    model_request(n);
    num_sodas = CNT_W'(n);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    num_sodas = CNT_W'($urandom);
    if (poke && n > 0) begin
      cyc($urandom_range(1, 5));
      num_sodas = CNT_W'($urandom_range(1, 15));
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    cyc(2);
    wait_idle(400);
  endtask

  initial begin
    int k;
    reset = 1'b1;
    cyc(3);
    chk("reset_circle", circle, 0);
    chk("reset_triangle", triangle, 0);
    chk("reset_pentagon", pentagon, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    chk("reset_sodas", sodas_got, 0);
    chk("reset_coins", coins_used, 0);
    reset = 1'b0;
    cyc(2);

    acc_credit = 0; cyc(1); request(1, 1'b0);
    acc_credit = 0; cyc(1); request(1, 1'b0);
    acc_credit = 0; cyc(1); request(3, 1'b1);

    // Zero-soda request: done next cycle, busy stays low
    model_request(0);
    num_sodas = '0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("zero_busy0", busy, 0);
    cyc(1); chk("zero_busy1", busy, 0);
    cyc(1); chk("zero_busy2", busy, 0);

    for (int i = 0; i < 25; i++) begin
      acc_credit = $urandom_range(0, 3);
      cyc(1);
      request($urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    // Reset while a coin is held
    acc_credit = $urandom_range(0, 3);
    cyc(1);
    model_request(2);
    num_sodas = CNT_W'(2);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 0;
    while ({pentagon, triangle, circle} == 3'b000 && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("hold_reached", int'({pentagon, triangle, circle} != 3'b000), 1);
    abort_flag = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    chk("abort_shapes", {pentagon, triangle, circle}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_error", error, 0);
    chk("abort_sodas", sodas_got, 0);
    chk("abort_coins", coins_used, 0);
    reset = 1'b0;
    exp_coin.delete();
    exp_done.delete();
    last_sodas = 0;
    last_coins = 0;
    cyc(3);
    acc_credit = $urandom_range(0, 3); cyc(1); request(2, 1'b0);

    // Acceptor stops crediting: first CHECK must fault and stay faulted
    acc_stuck = 1'b1;
    acc_credit = 0;
    cyc(2);
`ifdef VEND_PENTAGON_EN
    exp_coin.push_back(3'b100);
`else
    exp_coin.push_back(3'b010);
`endif
    exp_err++;
    num_sodas = CNT_W'(1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 0;
    while (!error && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk("error_reached", error, 1);
    num_sodas = CNT_W'(3);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc(10);
    chk("error_sticky", error, 1);
    chk("error_busy", busy, 1);
    chk("error_coins", coins_used, 1);
    chk("error_sodas", sodas_got, 0);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    acc_stuck = 1'b0;
    chk("error_cleared", error, 0);
    cyc(5);
    chk("queues_empty", exp_coin.size() + exp_done.size() + exp_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
